// File: rtl/pbus_pkg.sv
// Shared definitions for the peripheral-bus router: FSM state encoding,
// the all-ones data returned on failed reads, and the address-to-channel
// select helper.
package pbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_e;

  // Wide all-ones constant; users truncate it to their data width.
  localparam logic [63:0] RD_ERR_DATA = '1;

  // Channel select = the top sel_w bits of an addr_w-bit address.
  function automatic logic [31:0] ch_sel_f(input logic [31:0] addr,
                                           input int          addr_w,
                                           input int          sel_w);
    ch_sel_f = (addr >> (addr_w - sel_w)) & ((32'd1 << sel_w) - 32'd1);
  endfunction

endpackage

// File: rtl/pbus_router_if.sv
// Bundle of CPU-side and channel-side signals of the peripheral router.
// Signal names are given from the router's point of view (i_ = into the
// router, o_ = out of the router). The slave modport is the router, the
// master modport is the surrounding system (CPU plus channels).
interface pbus_router_if #(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // CPU side
  logic                     i_p_wr_strobe;
  logic                     i_p_rd_strobe;
  logic [ADDR_W-1:0]        i_p_addr;
  logic [DATA_W-1:0]        i_p_dout;
  logic [DATA_W-1:0]        o_p_din;
  logic                     o_p_rd_done;

  // Channel side
  logic [CH_NUM-1:0]        o_ch_wr_strobe;
  logic [CH_NUM-1:0]        o_ch_rd_strobe;
  logic [ADDR_W-1:0]        o_ch_addr;
  logic [DATA_W-1:0]        o_ch_dout;
  logic [CH_NUM*DATA_W-1:0] i_ch_din;
  logic [CH_NUM-1:0]        i_ch_rd_done;

  // Error reporting
  logic                     o_timeout_err;
  logic                     i_err_clr;

  modport slave (
    input  i_p_wr_strobe, i_p_rd_strobe, i_p_addr, i_p_dout,
    input  i_ch_din, i_ch_rd_done, i_err_clr,
    output o_p_din, o_p_rd_done,
    output o_ch_wr_strobe, o_ch_rd_strobe, o_ch_addr, o_ch_dout,
    output o_timeout_err
  );

  modport master (
    output i_p_wr_strobe, i_p_rd_strobe, i_p_addr, i_p_dout,
    output i_ch_din, i_ch_rd_done, i_err_clr,
    input  o_p_din, o_p_rd_done,
    input  o_ch_wr_strobe, o_ch_rd_strobe, o_ch_addr, o_ch_dout,
    input  o_timeout_err
  );

endinterface

// File: rtl/pbus_timeout_counter.sv
// Read-timeout counter. Loads to 0 when a read is launched, counts while
// the router waits, and flags expiry on the TIMEOUT-th waiting cycle.
// Only instantiated when PBUS_ROUTER_TIMEOUT_EN is defined.
module pbus_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_areset_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last   = (cnt_q == LAST);
  assign o_expired = i_enable & at_last;

  // Next count: restart on load, advance while enabled, park at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_enable && !at_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pbus_router.sv
// Peripheral-bus router: decodes the top address bits into one of CH_NUM
// channels, forwards writes as registered one-cycle strobes, and runs reads
// through a small IDLE / RD_WAIT / RD_RESP FSM. Reads to unmapped selects
// return all ones and set the sticky error flag.
// Optional read timeout: define PBUS_ROUTER_TIMEOUT_EN.
module pbus_router
  import pbus_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_areset_n,
  pbus_router_if.slave bus
);

  localparam int                 CH_SEL_W = $clog2(CH_NUM);
  localparam int                 SEL_SPAN = 1 << CH_SEL_W;
  localparam logic [CH_NUM-1:0]  CH_ONE   = CH_NUM'(1);
  localparam logic [DATA_W-1:0]  ERR_DATA = DATA_W'(RD_ERR_DATA);

  state_e              state_q, state_d;
  logic [CH_SEL_W-1:0] sel_in, sel_q, sel_d;
  logic [CH_NUM-1:0]   wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
  logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]   ch_dout_q, ch_dout_d, p_din_q, p_din_d;
  logic                err_q, err_d, err_set;

  logic [SEL_SPAN-1:0] map_mask, done_pad;
  logic [DATA_W-1:0]   din_arr [SEL_SPAN];
  logic                mapped_in, do_wr, do_rd, done_sel, expired;

  // Select space is padded to a power of two; padded slots are unmapped,
  // never report done and read as zero.
  for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_sel
    if (gi < CH_NUM) begin : g_map
      assign map_mask[gi] = 1'b1;
      assign done_pad[gi] = bus.i_ch_rd_done[gi];
      assign din_arr[gi]  = bus.i_ch_din[gi*DATA_W +: DATA_W];
    end else begin : g_unmap
      assign map_mask[gi] = 1'b0;
      assign done_pad[gi] = 1'b0;
      assign din_arr[gi]  = '0;
    end
  end

  assign sel_in    = CH_SEL_W'(ch_sel_f(32'(bus.i_p_addr), ADDR_W, CH_SEL_W));
  assign mapped_in = map_mask[sel_in];
  // Write has priority over a simultaneous read; strobes outside IDLE are dropped.
  assign do_wr     = (state_q == IDLE) & bus.i_p_wr_strobe;
  assign do_rd     = (state_q == IDLE) & bus.i_p_rd_strobe & ~bus.i_p_wr_strobe;
  // Only the channel being read may complete it.
  assign done_sel  = done_pad[sel_q];

`ifdef PBUS_ROUTER_TIMEOUT_EN
  pbus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_load     (do_rd & mapped_in),
    .i_enable   (state_q == RD_WAIT),
    .o_expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; unmapped reads skip the wait entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_rd) state_d = mapped_in ? RD_WAIT : RD_RESP;
      RD_WAIT: if (done_sel || expired) state_d = RD_RESP;
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: strobes, broadcast addr/data, read data, error flag.
  always_comb begin
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    ch_addr_d = ch_addr_q;
    ch_dout_d = ch_dout_q;
    sel_d     = sel_q;
    p_din_d   = p_din_q;
    err_set   = 1'b0;
    if (do_wr && mapped_in) begin
      ch_addr_d = bus.i_p_addr;
      ch_dout_d = bus.i_p_dout;
      wr_stb_d  = CH_ONE << sel_in;
    end
    if (do_rd) begin
      if (mapped_in) begin
        ch_addr_d = bus.i_p_addr;
        sel_d     = sel_in;
        rd_stb_d  = CH_ONE << sel_in;
      end else begin
        p_din_d = ERR_DATA;
        err_set = 1'b1;
      end
    end
    if (state_q == RD_WAIT) begin
      // A done in the expiry cycle still returns real data.
      if (done_sel) begin
        p_din_d = din_arr[sel_q];
      end else if (expired) begin
        p_din_d = ERR_DATA;
        err_set = 1'b1;
      end
    end
    // Setting the flag wins over a clear in the same cycle.
    err_d = err_set | (err_q & ~bus.i_err_clr);
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      ch_addr_q <= '0;
      ch_dout_q <= '0;
      sel_q     <= '0;
      p_din_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      ch_addr_q <= ch_addr_d;
      ch_dout_q <= ch_dout_d;
      sel_q     <= sel_d;
      p_din_q   <= p_din_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_ch_wr_strobe = wr_stb_q;
  assign bus.o_ch_rd_strobe = rd_stb_q;
  assign bus.o_ch_addr      = ch_addr_q;
  assign bus.o_ch_dout      = ch_dout_q;
  assign bus.o_p_din        = p_din_q;
  assign bus.o_p_rd_done    = (state_q == RD_RESP);
  assign bus.o_timeout_err  = err_q;

endmodule

// File: doc/pbus_router.md
# pbus_router

Parametrised peripheral-port router between the venera_cpu_1 peripheral interface and up to CH_NUM peripheral channels. It decodes the upper address bits into a channel select and registers write strobes out to the selected channel. It also runs read transactions through a small FSM, returning data and a one-cycle done pulse to the CPU. It replaces the point-to-point single-peripheral hookup at top level and adds multi-channel decode, unmapped-address handling and an optional read timeout.

## Interface
- CH_NUM, 4, number of peripheral channels, 2..16
- ADDR_W, 8, CPU peripheral address width
- DATA_W, 8, data width
- TIMEOUT, 16, read timeout in cycles, >= 2; used only with timeout compiled in
- CH_SEL_W is derived as $clog2(CH_NUM); it is a localparam, not a port parameter
- i_clk  in  1  clock
- i_areset_n  in  1  asynchronous active-low reset
- i_p_wr_strobe  in  1  CPU write strobe
- i_p_rd_strobe  in  1  CPU read strobe
- i_p_addr  in  ADDR_W  CPU address; [ADDR_W-1 -: CH_SEL_W] selects the channel
- i_p_dout  in  DATA_W  CPU write data
- o_p_din  out  DATA_W  read data to CPU
- o_p_rd_done  out  1  read complete pulse to CPU
- o_ch_wr_strobe  out  CH_NUM  one-hot write strobe
- o_ch_rd_strobe  out  CH_NUM  one-hot read strobe
- o_ch_addr  out  ADDR_W  registered address, broadcast to all channels
- o_ch_dout  out  DATA_W  registered write data, broadcast to all channels
- i_ch_din  in  CH_NUM*DATA_W  channel read data; channel k occupies [k*DATA_W +: DATA_W]
- i_ch_rd_done  in  CH_NUM  per-channel read done
- o_timeout_err  out  1  sticky flag: a read timed out or an unmapped read occurred
- i_err_clr  in  1  clears o_timeout_err

## Operation
- FSM states:
  - IDLE: accepts strobes.
  - RD_WAIT: waits for the selected channel's done, or for the timeout.
  - RD_RESP: drives o_p_rd_done for one cycle, then returns to IDLE.
- Write in IDLE:
  - Register addr and data.
  - Pulse o_ch_wr_strobe[sel] for one cycle.
  - FSM stays in IDLE.
- Read in IDLE:
  - Register addr and sel.
  - Pulse o_ch_rd_strobe[sel] for one cycle.
  - Go to RD_WAIT.
- RD_WAIT:
  - i_ch_rd_done[sel]=1 captures i_ch_din[sel] into o_p_din and moves to RD_RESP.
  - Done from non-selected channels is ignored.
- Unmapped select (sel >= CH_NUM):
  - Writes are dropped; no strobe is issued.
  - Reads issue no strobe, go directly to RD_RESP with o_p_din = all ones, and set o_timeout_err.
- Simultaneous wr and rd strobe in IDLE: the write executes and the read is dropped.
- Strobes arriving in RD_WAIT or RD_RESP are dropped, because the CPU stalls on reads.
- o_timeout_err:
  - Set wins over i_err_clr in the same cycle.
  - Otherwise i_err_clr clears it.
- Reset, including mid-transaction:
  - FSM returns to IDLE.
  - All outputs go to 0, except o_p_din, which goes to 0 as well.
  - Any pending read is abandoned; no done is issued.

## Timing
- Write strobe at cycle N -> o_ch_wr_strobe, o_ch_addr and o_ch_dout are valid at N+1, for exactly one cycle.
- Read strobe at cycle N -> o_ch_rd_strobe at N+1.
- Channel done at cycle M >= N+1 (done in the same cycle as the strobe is legal) -> o_p_rd_done and o_p_din at M+1.
- Minimum read latency is 2 cycles.
- o_p_din holds its value until the next read response.
- Back-to-back writes on consecutive cycles are all forwarded, one strobe per cycle.
- Unmapped read at cycle N -> o_p_rd_done at N+1.

## Configuration
- PBUS_ROUTER_TIMEOUT_EN defined:
  - A counter starts at 0 on entry to RD_WAIT.
  - If no done arrives after TIMEOUT cycles in RD_WAIT, move to RD_RESP with o_p_din = all ones and set o_timeout_err.
  - Worst-case done is at N+1+TIMEOUT.
  - Done and expiry in the same cycle: done wins and real data is returned.
- Not defined:
  - RD_WAIT waits indefinitely.
  - o_timeout_err is set only by unmapped reads.

## Structure
- Shared package/header pbus_pkg holds:
  - FSM state encodings: IDLE=2'd0, RD_WAIT=2'd1, RD_RESP=2'd2.
  - The all-ones read-error constant.
  - The channel-select slice helper.
- One sub-module, pbus_timeout_counter:
  - Interface: load, enable, expired.
  - Instantiated only under PBUS_ROUTER_TIMEOUT_EN.

## Test plan
- Write addr 0x45 with data 0xA5, CH_NUM=4 -> o_ch_wr_strobe=4'b0010 for one cycle at N+1; o_ch_addr=0x45; o_ch_dout=0xA5.
- Read addr 0xC3; channel 3 returns done 2 cycles after its strobe with data 0x3C -> o_ch_rd_strobe=4'b1000 at N+1; o_p_rd_done with o_p_din=0x3C at N+4.
- Wr and rd strobe together, plus a done from channel 1 while channel 2 is being read -> write forwarded, read dropped; stray done ignored and the read completes only on channel 2's done.
- CH_NUM=3, read addr 0xC0 -> no channel strobe; o_p_rd_done at N+1 with 0xFF; o_timeout_err=1; i_err_clr clears it.
- Macro on, TIMEOUT=16, no done -> o_p_rd_done at N+17 with 0xFF and o_timeout_err=1; done at the expiry cycle instead returns real data.
- Assert i_areset_n low while in RD_WAIT -> all outputs 0 and FSM in IDLE; a new read after release completes normally.
